// File: rtl/output_channel_scheduler.sv
// Drives the wavelet output multiplexer select: manual pass-through or round-robin
// scan of enabled channels with per-channel dwell, plus tags aligned to the mux output.
module output_channel_scheduler #(
  parameter int NUM_FILTERS = 8,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_scan_enable,
  input  logic [7:0]             i_manual_channel,
  input  logic [NUM_FILTERS-1:0] i_channel_enable_mask,
  input  logic [DWELL_WIDTH-1:0] i_dwell_samples,
  input  logic                   i_sample_valid,
  output logic [7:0]             o_select_output_channel,
  output logic                   o_out_valid,
  output logic [7:0]             o_out_channel,
  output logic                   o_frame_start,
  output logic                   o_scan_active
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             sel_q, sel_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   vld_q, vld_d;
  logic [7:0]             och_q, och_d;
  logic                   fs_q, fs_d;

  // Priority rotate: first enabled channel strictly above cur, wrapping around.
  function automatic logic [7:0] next_en(input logic [NUM_FILTERS-1:0] m,
                                         input logic [7:0] cur);
    logic [7:0]             r;
    logic [NUM_FILTERS-1:0] sh;
    int                     idx;
    r = cur;
    for (int i = NUM_FILTERS; i >= 1; i--) begin
      idx = int'(cur) + i;
      if (idx >= NUM_FILTERS) idx -= NUM_FILTERS;
      sh = m >> idx;
      if (sh[0]) r = 8'(idx);
    end
    return r;
  endfunction

  function automatic logic [7:0] lowest_en(input logic [NUM_FILTERS-1:0] m);
    logic [7:0]             r;
    logic [NUM_FILTERS-1:0] sh;
    r = 8'd0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      sh = m >> i;
      if (sh[0]) r = 8'(i);
    end
    return r;
  endfunction

  logic [NUM_FILTERS-1:0] cur_sh;
  logic                   cur_dis;
  logic [7:0]             nxt;
  assign cur_sh  = i_channel_enable_mask >> sel_q;
  assign cur_dis = ~cur_sh[0];
  assign nxt     = next_en(i_channel_enable_mask, sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    vld_d   = 1'b0;
    och_d   = och_q;
    fs_d    = 1'b0;

    if (!i_scan_enable)                  state_d = MANUAL;
    else if (i_channel_enable_mask == '0) state_d = IDLE;
    else                                 state_d = SCAN;

    // Tag uses the select currently presented to the mux.
    if (i_sample_valid && state_q != IDLE) begin
      vld_d = 1'b1;
      och_d = sel_q;
      fs_d  = (state_q == SCAN) && pend_q;
      pend_d = 1'b0;
    end

    case (state_d)
      IDLE: begin
        sel_d  = 8'd0;
        cnt_d  = '0;
        pend_d = 1'b0;
      end
      MANUAL: begin
        sel_d  = (int'(i_manual_channel) < NUM_FILTERS) ? i_manual_channel : 8'd0;
        cnt_d  = '0;
        pend_d = 1'b0;
      end
      default: begin
        if (state_q != SCAN) begin
          sel_d  = lowest_en(i_channel_enable_mask);
          cnt_d  = '0;
          pend_d = 1'b1;
        end else if ((i_sample_valid && (cnt_q >= i_dwell_samples)) || cur_dis) begin
          sel_d = nxt;
          cnt_d = '0;
          if (nxt <= sel_q) pend_d = 1'b1;
        end else if (i_sample_valid) begin
          cnt_d = cnt_q + DWELL_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 8'd0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      och_q   <= 8'd0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      och_q   <= och_d;
      fs_q    <= fs_d;
    end
  end

  assign o_select_output_channel = sel_q;
  assign o_out_valid             = vld_q;
  assign o_out_channel           = och_q;
  assign o_frame_start           = fs_q;
  assign o_scan_active           = (state_q == SCAN);

endmodule

// File: tb/tb_output_channel_scheduler.sv
// Directed checks of manual mode, round-robin scan, dwell, mask edits and reset.
module tb_output_channel_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [7:0] man_ch;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic       sv;
  logic [7:0] sel;
  logic       ovld;
  logic [7:0] och;
  logic       fs;
  logic       act;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  output_channel_scheduler #(.NUM_FILTERS(8), .DWELL_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_scan_enable(scan_en), .i_manual_channel(man_ch),
    .i_channel_enable_mask(mask), .i_dwell_samples(dwell), .i_sample_valid(sv),
    .o_select_output_channel(sel), .o_out_valid(ovld), .o_out_channel(och),
    .o_frame_start(fs), .o_scan_active(act)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b0; man_ch = 8'd0; mask = 8'd0; dwell = 8'd0; sv = 1'b0;
    cyc(); cyc();
    n_cmp++;
    if ({sel, ovld, och, fs, act} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset: sel=%0d vld=%0b ch=%0d fs=%0b act=%0b, required all 0",
               sel, ovld, och, fs, act);
    end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    man_ch = 8'd2;
    cyc();
    n_cmp++;
    if (sel !== 8'd2) begin n_bad++; $display("FAIL manual_sel: got %0d required 2", sel); end
    sv = 1'b1;
    cyc();
    sv = 1'b0;
    n_cmp++;
    if ({ovld, och, fs, act} !== {1'b1, 8'd2, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL manual_tag: vld=%0b ch=%0d fs=%0b act=%0b required 1/2/0/0", ovld, och, fs, act);
    end
    man_ch = 8'd9;
    cyc();
    n_cmp++;
    if ({ovld, och} !== {1'b0, 8'd2}) begin
      n_bad++;
      $display("FAIL manual_hold: vld=%0b ch=%0d required 0/2", ovld, och);
    end
    cyc();
    n_cmp++;
    if (sel !== 8'd0) begin n_bad++; $display("FAIL manual_clip: got %0d required 0", sel); end
  endtask

  task automatic test_scan_b2b();
    logic [7:0] seq [7];
    logic       fss [7];
    seq = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0};
    fss = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    scan_en = 1'b1; mask = 8'h07; dwell = 8'd1;
    cyc();
    n_cmp++;
    if ({sel, act} !== {8'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL scan_entry: sel=%0d act=%0b required 0/1", sel, act);
    end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (sel !== seq[k]) begin
        n_bad++; $display("FAIL b2b_sel[%0d]: got %0d required %0d", k, sel, seq[k]);
      end
      sv = 1'b1;
      cyc();
      n_cmp++;
      if ({ovld, och, fs} !== {1'b1, seq[k], fss[k]}) begin
        n_bad++;
        $display("FAIL b2b_tag[%0d]: vld=%0b ch=%0d fs=%0b required 1/%0d/%0b",
                 k, ovld, och, fs, seq[k], fss[k]);
      end
    end
    sv = 1'b0;
  endtask

  task automatic test_scan_sparse();
    logic [7:0] seq [4];
    logic       fss [4];
    seq = '{8'd1, 8'd5, 8'd7, 8'd1};
    fss = '{1'b1, 1'b0, 1'b0, 1'b1};
    scan_en = 1'b0;
    cyc();
    scan_en = 1'b1; mask = 8'hA2; dwell = 8'd0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (sel !== seq[k]) begin
        n_bad++; $display("FAIL sparse_sel[%0d]: got %0d required %0d", k, sel, seq[k]);
      end
      sv = 1'b1;
      cyc();
      sv = 1'b0;
      n_cmp++;
      if ({ovld, och, fs} !== {1'b1, seq[k], fss[k]}) begin
        n_bad++;
        $display("FAIL sparse_tag[%0d]: vld=%0b ch=%0d fs=%0b required 1/%0d/%0b",
                 k, ovld, och, fs, seq[k], fss[k]);
      end
      cyc();
      n_cmp++;
      if (ovld !== 1'b0) begin n_bad++; $display("FAIL sparse_pulse[%0d]: vld=%0b required 0", k, ovld); end
      cyc();
    end
  endtask

  // Enters on channel 5, counter 0 (left there by the sparse scan).
  task automatic test_mid_dwell_clear();
    dwell = 8'd3;
    sv = 1'b1;
    cyc();
    sv = 1'b0;
    n_cmp++;
    if (sel !== 8'd5) begin n_bad++; $display("FAIL dwell_hold: got %0d required 5", sel); end
    mask = 8'h82;
    cyc();
    n_cmp++;
    if ({sel, ovld} !== {8'd7, 1'b0}) begin
      n_bad++; $display("FAIL clear_adv: sel=%0d vld=%0b required 7/0", sel, ovld);
    end
    // A fresh counter needs four strobes on channel 7; three must not advance.
    for (int k = 0; k < 3; k++) begin
      sv = 1'b1;
      cyc();
    end
    sv = 1'b0;
    n_cmp++;
    if (sel !== 8'd7) begin n_bad++; $display("FAIL clear_cnt0: sel=%0d required 7", sel); end
  endtask

  task automatic test_simultaneous();
    dwell = 8'd200;
    cyc();
    mask = 8'h02; sv = 1'b1;
    cyc();
    n_cmp++;
    if ({ovld, och, fs, sel} !== {1'b1, 8'd7, 1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL force_adv: vld=%0b ch=%0d fs=%0b sel=%0d required 1/7/0/1", ovld, och, fs, sel);
    end
    cyc();
    sv = 1'b0;
    n_cmp++;
    if ({ovld, och, fs} !== {1'b1, 8'd1, 1'b1}) begin
      n_bad++; $display("FAIL force_wrap: vld=%0b ch=%0d fs=%0b required 1/1/1", ovld, och, fs);
    end
    mask = 8'h00;
    cyc();
    n_cmp++;
    if ({sel, act} !== {8'd0, 1'b0}) begin
      n_bad++; $display("FAIL idle: sel=%0d act=%0b required 0/0", sel, act);
    end
    sv = 1'b1;
    cyc();
    sv = 1'b0;
    n_cmp++;
    if ({ovld, fs} !== 2'b00) begin
      n_bad++; $display("FAIL idle_tag: vld=%0b fs=%0b required 0/0", ovld, fs);
    end
  endtask

  task automatic test_reset_mid_scan();
    mask = 8'h06; dwell = 8'd0;
    cyc();
    n_cmp++;
    if ({sel, act} !== {8'd1, 1'b1}) begin
      n_bad++; $display("FAIL rs_entry: sel=%0d act=%0b required 1/1", sel, act);
    end
    sv = 1'b1;
    cyc();
    n_cmp++;
    if ({och, fs, sel} !== {8'd1, 1'b1, 8'd2}) begin
      n_bad++; $display("FAIL rs_first: ch=%0d fs=%0b sel=%0d required 1/1/2", och, fs, sel);
    end
    cyc();
    rst = 1'b1;
    cyc();
    n_cmp++;
    if ({sel, ovld, och, fs, act} !== 19'd0) begin
      n_bad++;
      $display("FAIL rs_reset: sel=%0d vld=%0b ch=%0d fs=%0b act=%0b required all 0",
               sel, ovld, och, fs, act);
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if ({sel, act, ovld} !== {8'd1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL rs_restart: sel=%0d act=%0b vld=%0b required 1/1/0", sel, act, ovld);
    end
    cyc();
    sv = 1'b0;
    n_cmp++;
    if ({ovld, och, fs} !== {1'b1, 8'd1, 1'b1}) begin
      n_bad++; $display("FAIL rs_frame: vld=%0b ch=%0d fs=%0b required 1/1/1", ovld, och, fs);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_b2b();
    test_scan_sparse();
    test_mid_dwell_clear();
    test_simultaneous();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
